// File: rtl/sonic_vc_tx_pkg.sv
// Shared widths, payload layout and framing-checker state encoding for the
// VC TX FIFO output adapter.
package sonic_vc_tx_pkg;

  localparam int DATA_W    = 128;
  localparam int EMPTY_W   = 2;
  localparam int PAYLOAD_W = DATA_W + 3 + EMPTY_W;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } chk_state_e;

  // Field order defines the bit-exact 133-bit beat: {data, channel, sop, eop, empty}.
  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               channel;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } payload_t;

endpackage

// File: rtl/sonic_vc_tx_ready_delay.sv
// Delays the downstream ready by STAGES register stages to form the FIFO-side
// grant; STAGES=0 passes ready straight through.
module sonic_vc_tx_ready_delay
  import sonic_vc_tx_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic ready,
  output logic grant
);

  generate
    if (STAGES == 0) begin : g_comb
      assign grant = ready;
    end else begin : g_pipe
      logic [STAGES-1:0] pipe;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pipe <= '0;
        end else begin
          pipe[0] <= ready;
          for (int i = 1; i < STAGES; i++) begin
            pipe[i] <= pipe[i-1];
          end
        end
      end

      assign grant = pipe[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/sonic_vc_tx_fifo_out_adapter.sv
// Converts the ready-latency-0 TX FIFO read side to a READY_LATENCY sink with one
// output register stage; framing checker built only with SONIC_VC_TX_OUT_ADAPTER_PKT_CHECK_EN.
//   state  | meaning
//   IDLE   | between packets, next accepted beat must carry sop
//   IN_PKT | inside a packet, waiting for eop
module sonic_vc_tx_fifo_out_adapter
  import sonic_vc_tx_pkg::*;
#(
  parameter int READY_LATENCY = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               in_ready,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_channel,
  input  logic               in_startofpacket,
  input  logic               in_endofpacket,
  input  logic [EMPTY_W-1:0] in_empty,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_channel,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty,
  output logic               out_error,
  output logic [7:0]         err_count
);

  logic     grant;
  logic     xfer;
  payload_t in_word;
  payload_t out_word;

  sonic_vc_tx_ready_delay #(
    .STAGES(READY_LATENCY - 1)
  ) u_ready_delay (
    .clk   (clk),
    .reset (reset),
    .ready (out_ready),
    .grant (grant)
  );

  // Gating with reset keeps in_ready low during reset even when the grant is combinational.
  assign in_ready = grant & ~reset;
  assign xfer     = in_valid & in_ready;
  assign in_word  = {in_data, in_channel, in_startofpacket, in_endofpacket, in_empty};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_word  <= '0;
    end else begin
      out_valid <= xfer;
      if (xfer) begin
        out_word <= in_word;
      end
    end
  end

  assign out_data          = out_word.data;
  assign out_channel       = out_word.channel;
  assign out_startofpacket = out_word.sop;
  assign out_endofpacket   = out_word.eop;
  assign out_empty         = out_word.empty;

`ifdef SONIC_VC_TX_OUT_ADAPTER_PKT_CHECK_EN
  chk_state_e state;
  chk_state_e state_next;
  logic       beat_err;
  logic       err_pulse;
  logic [7:0] err_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    beat_err   = 1'b0;
    if (xfer) begin
      if ((in_empty != '0) && !in_endofpacket) begin
        beat_err = 1'b1;
      end
      case (state)
        IDLE: begin
          if (in_startofpacket) begin
            if (!in_endofpacket) begin
              state_next = IN_PKT;
            end
          end else begin
            beat_err = 1'b1;
          end
        end
        IN_PKT: begin
          // A sop here restarts the packet; eop still closes it.
          if (in_startofpacket) begin
            beat_err = 1'b1;
          end
          if (in_endofpacket) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_pulse <= 1'b0;
      err_cnt   <= 8'd0;
    end else begin
      err_pulse <= beat_err;
      if (beat_err && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  assign out_error = err_pulse;
  assign err_count = err_cnt;
`else
  assign out_error = 1'b0;
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_sonic_vc_tx_fifo_out_adapter.sv
// Self-checking bench for sonic_vc_tx_fifo_out_adapter: scoreboard of accepted beats
// plus a framing vector table; expectations follow SONIC_VC_TX_OUT_ADAPTER_PKT_CHECK_EN.
module tb_sonic_vc_tx_fifo_out_adapter;
  import sonic_vc_tx_pkg::*;

  localparam int RL = 2;
`ifdef SONIC_VC_TX_OUT_ADAPTER_PKT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef logic [PAYLOAD_W-1:0] w_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_ready;
  logic               in_valid = 1'b0;
  logic [DATA_W-1:0]  in_data = '0;
  logic               in_channel = 1'b0;
  logic               in_startofpacket = 1'b0;
  logic               in_endofpacket = 1'b0;
  logic [EMPTY_W-1:0] in_empty = '0;
  logic               out_ready = 1'b0;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic               out_channel;
  logic               out_startofpacket;
  logic               out_endofpacket;
  logic [EMPTY_W-1:0] out_empty;
  logic               out_error;
  logic [7:0]         err_count;

  always #5 clk = ~clk;

  sonic_vc_tx_fifo_out_adapter #(.READY_LATENCY(RL)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_channel        (in_channel),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_empty          (in_empty),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_channel       (out_channel),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_empty         (out_empty),
    .out_error         (out_error),
    .err_count         (err_count)
  );

  typedef struct {
    payload_t p;
    logic     err;
  } beat_t;

  typedef struct {
    logic       valid;
    logic       ready;
    logic       sop;
    logic       eop;
    logic [1:0] empty;
    logic       exp_err;
  } vec_t;

  beat_t    q[$];
  int       n_checks = 0;
  int       n_fail = 0;
  int       beats_seen = 0;
  logic     exp_valid_next = 1'b0;
  payload_t last_payload = '0;
  logic [7:0] exp_cnt = 8'd0;
  logic [3:0] or_hist = 4'd0;

  task automatic check(input string name, input w_t act, input w_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic payload_t mk(input logic sop, input logic eop, input logic [1:0] emp);
    payload_t p;
    p.data    = {$urandom(), $urandom(), $urandom(), $urandom()};
    p.channel = 1'($urandom_range(0, 1));
    p.sop     = sop;
    p.eop     = eop;
    p.empty   = emp;
    return p;
  endfunction

  task automatic check_outputs();
    payload_t got;
    beat_t    b;
    got = {out_data, out_channel, out_startofpacket, out_endofpacket, out_empty};
    check("out_valid", w_t'(out_valid), w_t'(exp_valid_next));
    if (exp_valid_next) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard: got beat expected none queued");
      end else begin
        b = q.pop_front();
        check("payload", w_t'(got), w_t'(b.p));
        check("out_error", w_t'(out_error), w_t'(b.err && CHK));
        last_payload = b.p;
        if (b.err && CHK && (exp_cnt != 8'hFF)) exp_cnt = exp_cnt + 8'd1;
        beats_seen++;
      end
    end else begin
      check("payload_hold", w_t'(got), w_t'(last_payload));
      check("out_error_idle", w_t'(out_error), w_t'(1'b0));
    end
    check("err_count", w_t'(err_count), w_t'(exp_cnt));
  endtask

  task automatic cyc(input logic v, input logic r, input payload_t p, input logic err);
    beat_t b;
    @(posedge clk);
    #1;
    check_outputs();
    in_valid = v;
    out_ready = r;
    {in_data, in_channel, in_startofpacket, in_endofpacket, in_empty} = p;
    or_hist = {or_hist[2:0], r};
    #1;
    check("in_ready", w_t'(in_ready), w_t'(or_hist[RL-1]));
    exp_valid_next = v && or_hist[RL-1];
    if (exp_valid_next) begin
      b.p = p;
      b.err = err;
      q.push_back(b);
    end
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, '0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_out_valid", w_t'(out_valid), w_t'(1'b0));
    check("rst_in_ready", w_t'(in_ready), w_t'(1'b0));
    check("rst_out_error", w_t'(out_error), w_t'(1'b0));
    check("rst_err_count", w_t'(err_count), w_t'(8'd0));
    check("rst_payload", w_t'({out_data, out_channel, out_startofpacket, out_endofpacket, out_empty}), '0);
    in_valid = 1'b0;
    out_ready = 1'b0;
    q.delete();
    exp_valid_next = 1'b0;
    last_payload = '0;
    exp_cnt = 8'd0;
    or_hist = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  vec_t vecs[12];
  payload_t pa5;
  logic [DATA_W-1:0] a5;

  initial begin
    vecs[0]  = '{1, 1, 1, 0, 2'd0, 0};
    vecs[1]  = '{1, 1, 0, 0, 2'd0, 0};
    vecs[2]  = '{1, 1, 0, 1, 2'd3, 0};
    vecs[3]  = '{1, 1, 1, 1, 2'd2, 0};
    vecs[4]  = '{1, 1, 0, 0, 2'd0, 1};
    vecs[5]  = '{1, 1, 1, 0, 2'd1, 1};
    vecs[6]  = '{1, 1, 1, 0, 2'd0, 1};
    vecs[7]  = '{1, 1, 0, 1, 2'd0, 0};
    vecs[8]  = '{1, 1, 0, 1, 2'd0, 1};
    vecs[9]  = '{1, 1, 1, 0, 2'd0, 0};
    vecs[10] = '{1, 1, 0, 0, 2'd2, 1};
    vecs[11] = '{1, 1, 0, 1, 2'd1, 0};

    #2;
    do_reset();

    // Back-to-back: out_ready held high, 8 beats.
    cyc(1'b0, 1'b1, '0, 1'b0);
    beats_seen = 0;
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, mk(1'b1, 1'b1, 2'(i)), 1'b0);
    flush(3);
    check("b2b_beats", w_t'(beats_seen), w_t'(8));

    // out_ready toggling with in_valid always high.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, (i % 2) == 0, mk(1'b1, 1'b1, 2'd0), 1'b0);
    flush(3);

    // Hold behaviour while granted but idle.
    do_reset();
    a5 = {16{8'hA5}};
    pa5 = mk(1'b1, 1'b1, 2'd0);
    pa5.data = a5;
    cyc(1'b0, 1'b1, '0, 1'b0);
    cyc(1'b1, 1'b1, pa5, 1'b0);
    flush(4);
    check("hold_a5", w_t'(out_data), w_t'(a5));

    // Framing vector table.
    do_reset();
    cyc(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 12; i++)
      cyc(vecs[i].valid, vecs[i].ready, mk(vecs[i].sop, vecs[i].eop, vecs[i].empty), vecs[i].exp_err);
    flush(2);

    // sop, sop, eop then saturation.
    do_reset();
    cyc(1'b0, 1'b1, '0, 1'b0);
    cyc(1'b1, 1'b1, mk(1'b1, 1'b0, 2'd0), 1'b0);
    cyc(1'b1, 1'b1, mk(1'b1, 1'b0, 2'd0), 1'b1);
    cyc(1'b1, 1'b1, mk(1'b0, 1'b1, 2'd0), 1'b0);
    flush(2);
    check("err_count_sse", w_t'(err_count), w_t'(CHK ? 8'd1 : 8'd0));
    for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, mk(1'b0, 1'b0, 2'd0), 1'b1);
    flush(2);
    check("err_count_sat", w_t'(err_count), w_t'(CHK ? 8'd255 : 8'd0));

    // Reset mid-packet with a beat in flight.
    do_reset();
    cyc(1'b0, 1'b1, '0, 1'b0);
    cyc(1'b1, 1'b1, mk(1'b1, 1'b0, 2'd0), 1'b0);
    cyc(1'b1, 1'b1, mk(1'b0, 1'b0, 2'd0), 1'b0);
    do_reset();
    cyc(1'b1, 1'b1, mk(1'b0, 1'b1, 2'd0), 1'b1);
    cyc(1'b1, 1'b1, mk(1'b0, 1'b1, 2'd0), 1'b1);
    flush(2);
    check("err_after_reset", w_t'(err_count), w_t'(CHK ? 8'd1 : 8'd0));

    check("queue_empty", w_t'(q.size()), w_t'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sonic_vc_tx_fifo_out_adapter.md
SONIC_VC_TX_FIFO_OUT_ADAPTER -- requirements
Module: sonic_vc_tx_fifo_out_adapter

Interface
REQ-001 Parameter READY_LATENCY, default 2, legal range 1..4: sink-side ready latency in cycles.
REQ-002 clk  in  1  single clock; all logic is on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 in_ready  out  1  ready to the TX FIFO read side (ready latency 0).
REQ-005 in_valid  in  1  FIFO word valid.
REQ-006 in_data  in  128  FIFO payload data.
REQ-007 in_channel, in_startofpacket, in_endofpacket  in  1 each  FIFO sideband.
REQ-008 in_empty  in  2  empty-symbol count, meaningful only with in_endofpacket.
REQ-009 out_ready  in  1  downstream ready (ready latency = READY_LATENCY).
REQ-010 out_valid  out  1  downstream valid.
REQ-011 out_data, out_channel, out_startofpacket, out_endofpacket, out_empty  out  128/1/1/1/2  registered copy of the accepted FIFO word.
REQ-012 out_error  out  1  one-cycle framing-error pulse.
REQ-013 err_count  out  8  saturating framing-error count.

Function
REQ-014 Internal grant = out_ready delayed by READY_LATENCY-1 register stages; for READY_LATENCY=1, grant = out_ready combinationally.
REQ-015 in_ready shall equal grant; an input transfer occurs when in_valid && in_ready.
REQ-016 On an input transfer in cycle t, the payload shall be registered and out_valid shall be 1 in cycle t+1; otherwise out_valid shall be 0 in t+1.
REQ-017 out_valid shall be asserted only READY_LATENCY cycles after a cycle with out_ready=1; each downstream-ready cycle yields at most one beat.
REQ-018 The payload registers shall hold their value while out_valid=0; there is no internal storage beyond one output stage, and no beat is dropped or duplicated.
REQ-019 Payload order on out_* shall be {data, channel, sop, eop, empty} with a 133-bit total, preserved bit-exact.
REQ-020 A continuous out_ready=1 shall give full throughput, one beat per cycle, after an initial READY_LATENCY-cycle fill.
REQ-021 When out_ready deasserts at cycle t, beats already granted in cycles up to t+READY_LATENCY-1 shall still be delivered; none after that.

Reset
REQ-022 While reset=1: the grant pipeline, out_valid, all payload outputs, out_error, err_count and the framing state shall be 0/IDLE; in_ready shall be 0.
REQ-023 Reset mid-packet shall discard the in-flight beat; after release, the first accepted beat shall be checked from IDLE.
REQ-024 After reset deasserts, in_ready shall remain 0 until out_ready has propagated through the grant pipeline.

Configuration
REQ-025 Macro SONIC_VC_TX_OUT_ADAPTER_PKT_CHECK_EN shall compile in the framing checker; without it, out_error and err_count shall be tied to 0 and no checker logic shall be present.
REQ-026 The checker state machine has states IDLE and IN_PKT, and evaluates accepted input beats only.
REQ-027 In IDLE: sop shall move to IN_PKT, unless eop is also set, in which case it stays IDLE. A beat without sop is an error and stays IDLE.
REQ-028 In IN_PKT: eop shall move to IDLE. A sop beat is an error, and the state stays IN_PKT (treated as the new packet start).
REQ-029 A nonzero empty on a non-eop beat is an error, with no state effect.
REQ-030 An error shall pulse out_error aligned with the offending beat's out_valid cycle; err_count shall increment by 1 and saturate at 255.
REQ-031 Errors never block or alter data flow.

Structure
REQ-032 Shared package sonic_vc_tx_pkg shall hold DATA_W=128, EMPTY_W=2, PAYLOAD_W=133 and the checker state enum.
REQ-033 Sub-module sonic_vc_tx_ready_delay shall implement the parameterized ready shift register.

Verification
REQ-034 The bench shall cover: READY_LATENCY=2, out_ready held 1, 8 beats offered back-to-back -> first out_valid 2 cycles after the first out_ready, then 8 consecutive beats with identical payloads.
REQ-035 The bench shall cover: out_ready pattern 1,0,1,0 with in_valid always 1 -> out_valid pattern 1,0,1,0 delayed 2 cycles, and the in_ready pattern delayed 1 cycle.
REQ-036 The bench shall cover: in_valid=0 while granted -> out_valid=0 and out_data holding its prior value (e.g. 0xA5..A5).
REQ-037 The bench shall cover, with the checker enabled: sop, sop, eop sequence -> a single out_error pulse on beat 2 and err_count=1; 300 errors -> err_count=255.
REQ-038 The bench shall cover: reset asserted mid-packet with one beat granted -> out_valid=0 immediately, and after release a non-sop first beat flags an error.
REQ-039 The bench shall cover, with the macro undefined: the same error stimulus -> out_error=0 and err_count=0 throughout.
